mem_bus_if: RTL

//  Memory bus interface for the 8-bit RISC CPU, directly downstream of the control FSM.
//  - Turns the control strobes (rd, wr, sel) into request/acknowledge transactions
//    on a wait-stated memory bus.
//  - Latches read data for the instruction register and accumulator.
//  - Queues one access that arrives while the bus is busy.
//  - Reports protocol errors to the CPU.

---
 rtl/mem_bus_if.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_if.sv
// mem_bus_if: memory bus interface for the 8-bit RISC CPU.
//
// Turns the level strobes rd/wr from the control FSM into request/acknowledge
// transactions on a wait-stated memory bus. A launch is the rising edge of rd or
// wr. One launch arriving while the bus is busy is parked in a single-entry
// pending buffer. Read data is latched on cpu_rdata for the IR and accumulator.
// Protocol problems raise a sticky err flag that only rst clears.
//
// Optional feature: define MEMBUS_TIMEOUT_EN to abort a request that has not
// been acknowledged within TIMEOUT cycles. Without it, a request waits forever.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   rd, wr, sel          control strobes; sel picks pc_addr (1) or ir_addr (0)
//   pc_addr, ir_addr     address sources
//   acc_out              write data source
//   mem_addr, mem_wdata  registered bus address / write data
//   mem_req, mem_we      bus request (held until ack) and direction
//   mem_ack, mem_rdata   bus acknowledge (single cycle) and read data
//   cpu_rdata            last completed read data
//   done                 one-cycle completion pulse
//   busy                 transaction active or pending
//   err                  sticky protocol error
module mem_bus_if #(
    parameter int unsigned AW      = 13,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic          wr,
    input  logic          sel,
    input  logic [AW-1:0] pc_addr,
    input  logic [AW-1:0] ir_addr,
    input  logic [DW-1:0] acc_out,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_req,
    output logic          mem_we,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          done,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e        state_q;
    logic          rd_q, wr_q;
    logic          pend_valid_q;
    logic [AW-1:0] pend_addr_q;
    logic          pend_we_q;
    logic [DW-1:0] pend_wdata_q;

    logic          rd_rise, wr_rise, launch;
    logic [AW-1:0] launch_addr;
    logic          pend_store, pend_take, pend_drop;
    logic          timeout_hit;

    assign rd_rise     = rd & ~rd_q;
    assign wr_rise     = wr & ~wr_q;
    assign launch      = rd_rise | wr_rise;
    assign launch_addr = sel ? pc_addr : ir_addr;

    // In IDLE a full pending entry is promoted to the bus this cycle, so a
    // coincident launch takes its place; elsewhere a launch needs a free slot.
    assign pend_take  = (state_q == StIdle) & pend_valid_q;
    assign pend_store = launch & ((state_q == StIdle) ? pend_valid_q : ~pend_valid_q);
    assign pend_drop  = launch & (state_q != StIdle) & pend_valid_q;

`ifdef MEMBUS_TIMEOUT_EN
    localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] ToLast  = CW'(TIMEOUT - 1);

    logic [CW-1:0] to_cnt_q;

    // Abort on the edge where the count would reach TIMEOUT, so mem_req stays
    // high for exactly TIMEOUT cycles.
    assign timeout_hit = (to_cnt_q == ToLast);

    always_ff @(posedge clk) begin
        if (rst || state_q != StReq) begin
            to_cnt_q <= '0;
        end else if (!mem_ack) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_we_q    <= 1'b0;
            pend_wdata_q <= '0;
        end else if (pend_store) begin
            pend_valid_q <= 1'b1;
            pend_addr_q  <= launch_addr;
            pend_we_q    <= wr_rise;
            pend_wdata_q <= acc_out;
        end else if (pend_take) begin
            pend_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            cpu_rdata <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            rd_q <= rd;
            wr_q <= wr;
            unique case (state_q)
                StIdle: begin
                    if (pend_valid_q) begin
                        state_q  <= StReq;
                        mem_req  <= 1'b1;
                        mem_addr <= pend_addr_q;
                        mem_we   <= pend_we_q;
                        if (pend_we_q) mem_wdata <= pend_wdata_q;
                        busy     <= 1'b1;
                    end else if (launch) begin
                        state_q  <= StReq;
                        mem_req  <= 1'b1;
                        mem_addr <= launch_addr;
                        mem_we   <= wr_rise;
                        if (wr_rise) mem_wdata <= acc_out;
                        busy     <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                StReq: begin
                    busy <= 1'b1;
                    if (mem_ack) begin
                        state_q <= StDone;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        if (!mem_we) cpu_rdata <= mem_rdata;
                    end else if (timeout_hit) begin
                        state_q <= StDone;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                    // Either the waiting entry or a fresh launch keeps us busy.
                    busy    <= pend_valid_q | launch;
                end
                default: state_q <= StIdle;
            endcase
            if ((rd_rise & wr_rise) | pend_drop | (mem_ack & (state_q != StReq))) begin
                err <= 1'b1;
            end
        end
    end

endmodule
